// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Summary  : Two-stage valid/ready bitwise logic unit (8 ops) with registered
//            NZCV flags and a saturating completed-operation counter.
//            Define LOGIC_UNIT_STICKY_EN to add the sticky_zn flag history.
// Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic [CNT_W-1:0] op_count,
    input  logic             cnt_clr
`ifdef LOGIC_UNIT_STICKY_EN
    ,
    output logic [1:0]       sticky_zn
`endif
);

    localparam logic [2:0]       c_OP_AND  = 3'b000;
    localparam logic [2:0]       c_OP_OR   = 3'b001;
    localparam logic [2:0]       c_OP_XOR  = 3'b010;
    localparam logic [2:0]       c_OP_NAND = 3'b011;
    localparam logic [2:0]       c_OP_NOR  = 3'b100;
    localparam logic [2:0]       c_OP_XNOR = 3'b101;
    localparam logic [2:0]       c_OP_NOTA = 3'b110;
    localparam logic [2:0]       c_OP_PASS = 3'b111;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_r;
    logic             r_z;
    logic             r_n;
    logic             r_c;
    logic             r_v;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_load;
    logic             w_s1_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_res;

    // Stage 2 frees up either when empty or when its result leaves this cycle.
    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_load;
    assign w_in_xfer  = in_valid && w_s1_ready;
    assign w_out_xfer = r_s2_valid && out_ready;

    always_comb begin
        w_res = '0;
        case (r_s1_op)
            c_OP_AND:  w_res = r_s1_a & r_s1_b;
            c_OP_OR:   w_res = r_s1_a | r_s1_b;
            c_OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            c_OP_NAND: w_res = ~(r_s1_a & r_s1_b);
            c_OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
            c_OP_XNOR: w_res = ~(r_s1_a ^ r_s1_b);
            c_OP_NOTA: w_res = ~r_s1_a;
            c_OP_PASS: w_res = r_s1_a;
            default:   w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    // Operand registers carry no reset; their contents only matter under r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_op <= op;
            r_s1_a  <= a;
            r_s1_b  <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_r        <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_r <= w_res;
                r_z <= (w_res == '0);
                r_n <= w_res[WIDTH-1];
                r_c <= 1'b0;
                r_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out_xfer && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef LOGIC_UNIT_STICKY_EN
    logic [1:0] r_sticky;

    // A flag seen on a transfer wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 2'b00;
        end else begin
            if (w_out_xfer && r_z) begin
                r_sticky[1] <= 1'b1;
            end else if (cnt_clr) begin
                r_sticky[1] <= 1'b0;
            end
            if (w_out_xfer && r_n) begin
                r_sticky[0] <= 1'b1;
            end else if (cnt_clr) begin
                r_sticky[0] <= 1'b0;
            end
        end
    end

    assign sticky_zn = r_sticky;
`endif

    assign in_ready  = w_s1_ready;
    assign out_valid = r_s2_valid;
    assign r         = r_r;
    assign z         = r_z;
    assign n         = r_n;
    assign c         = r_c;
    assign v         = r_v;
    assign op_count  = r_cnt;

endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor of the team's 4-bit combinational AND/flags slice.
- Supports eight bitwise operations on WIDTH-bit operands and produces registered NZCV flags, matching the FPGAController ALU flag convention.
- Two-stage valid/ready pipeline with full backpressure, plus a saturating count of completed operations.
- Sits between the FPGAController operand registers and the result/flag display path.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op present.
- in_ready  output  1  stage 1 can accept.
- op  input  3  000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 PASS A.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for 110/111).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- r  output  WIDTH  registered result.
- z, n, c, v  output  1 each  registered flags for r.
- op_count  output  CNT_W  number of results accepted downstream; saturates.
- cnt_clr  input  1  synchronous clear of op_count.

Behaviour:
- Reset (rst_n low, asynchronous): stage-1 and stage-2 valid = 0, r = 0, z = 0, n = 0, c = 0, v = 0, op_count = 0. in_ready = 1 one cycle after release; internal data registers may be left unreset.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Stage 1 captures a, b and op on an input transfer.
- Stage 2 computes the selected function from stage-1 contents and registers r and flags on the stage-1 to stage-2 advance.
- Latency: 2 cycles from input transfer to out_valid, with an unstalled output.
- Advance condition: stage 2 loads when it is empty or is transferring out in the same cycle.
  - s1 ready = !s1_valid | s2_load.
  - in_ready = s1 ready (combinational from out_ready).
- Throughput: one result per cycle when out_ready is held high.
- No loss or duplication under any in_valid/out_ready pattern.
- Full (both stages valid, out_ready = 0): in_ready = 0; r/flags/out_valid held stable until accepted.
- Simultaneous input transfer and output transfer in the same cycle: both occur and the pipeline stays full.
- Flags:
  - z = (r == 0).
  - n = r[WIDTH-1].
  - c = 0 and v = 0 for all ops.
- NOT A: r = ~a. PASS A: r = a.
- op_count:
  - Increments on each output transfer.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority: when cnt_clr is high in a transfer cycle, the result is 0, not 1.
- Reset asserted mid-operation: all in-flight results are discarded; no out_valid after release until a new input transfer.
- out_valid is never asserted combinationally from in_valid.

Optional Feature:
- Macro: LOGIC_UNIT_STICKY_EN.
- When defined:
  - Extra output sticky_zn (2 bits: [1] = z seen, [0] = n seen), set on any output transfer whose z/n = 1.
  - Cleared by cnt_clr; cleared to 0 on reset.
  - Set takes priority over clear only if both occur in the same cycle as a transfer with the flag set.
- When undefined: port absent, no extra registers; all other behaviour identical.

Test Plan:
- Reset, then WIDTH=4, op=000, a=4'b1100, b=4'b1010, out_ready=1 -> out_valid exactly 2 cycles after transfer, r=4'b1000, z=0, n=1, c=0, v=0.
- op=000, a=4'hF, b=4'h0 -> r=0, z=1, n=0. Then op=110, a=4'h0 -> r=4'hF, n=1, z=0.
- 10 back-to-back inputs, out_ready held low -> in_ready drops after 2 accepted. Release out_ready -> all 10 results in order, one per cycle, op_count=10.
- WIDTH=8, CNT_W=2, 5 results accepted -> op_count saturates at 3. Pulse cnt_clr in the same cycle as a transfer -> op_count=0.
- Both stages full, rst_n pulsed low mid-cycle -> out_valid=0 and r=0 immediately (asynchronous). After release, no output until new input.
- LOGIC_UNIT_STICKY_EN defined: results 0x0 then 0x8 (WIDTH=4) -> sticky_zn=2'b11. cnt_clr -> 2'b00.
